// File: rtl/decode_pipe.sv
// RV32I(+M) decode stage: one register slice between fetch and execute, with a
// ready/valid handshake on both sides and load-use hazard detection.
module decode_pipe #(
    parameter int XLEN       = 32,
    parameter bit EN_MULDIV  = 1'b0,
    parameter bit EN_ILLEGAL = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ready,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_stall,
    output logic [5:0]      o_format,
    output logic            o_alu_imm,
    output logic            o_alu_pc,
    output logic [1:0]      o_wb_sel,
    output logic            o_reg_we,
    output logic            o_dmem_we,
    output logic            o_dmem_re,
    output logic [2:0]      o_opsel,
    output logic            o_sub,
    output logic            o_arith,
    output logic            o_unsigned,
    output logic            o_muldiv,
    output logic            o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_d, rs2_d, rd_d;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign rs1_d  = i_inst[19:15];
    assign rs2_d  = i_inst[24:20];
    assign rd_d   = i_inst[11:7];

    logic [5:0] format_d;
    logic       alu_imm_d, alu_pc_d;
    logic [1:0] wb_sel_d;
    logic [2:0] opsel_d;
    logic       sub_d, arith_d, unsigned_d, muldiv_d;
    logic       bad_d, writes_d, loads_d, stores_d;
    logic       reg_we_d, dmem_we_d, dmem_re_d, illegal_d;

    always_comb begin
        format_d   = '0;
        alu_imm_d  = 1'b0;
        alu_pc_d   = 1'b0;
        wb_sel_d   = 2'b00;
        opsel_d    = 3'b000;
        sub_d      = 1'b0;
        arith_d    = 1'b0;
        unsigned_d = 1'b0;
        muldiv_d   = 1'b0;
        bad_d      = 1'b0;
        writes_d   = 1'b0;
        loads_d    = 1'b0;
        stores_d   = 1'b0;
        // Opcodes with inst[1:0] != 11 never match below and land in default.
        case (opcode)
            OPC_OP: begin
                format_d   = FMT_R;
                opsel_d    = funct3;
                unsigned_d = funct3[0];
                sub_d      = (funct3 == 3'b000) & funct7[5];
                arith_d    = (funct3 == 3'b101) & funct7[5];
                writes_d   = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (EN_MULDIV) muldiv_d = 1'b1;
                    else           bad_d    = 1'b1;
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    bad_d = 1'b1;
                end
            end
            OPC_OPIMM: begin
                format_d   = FMT_I;
                alu_imm_d  = 1'b1;
                opsel_d    = funct3;
                unsigned_d = funct3[0];
                arith_d    = (funct3 == 3'b101) & i_inst[30];
                writes_d   = 1'b1;
            end
            OPC_LOAD: begin
                format_d  = FMT_I;
                alu_imm_d = 1'b1;
                wb_sel_d  = 2'b01;
                writes_d  = 1'b1;
                loads_d   = 1'b1;
            end
            OPC_STORE: begin
                format_d  = FMT_S;
                alu_imm_d = 1'b1;
                stores_d  = 1'b1;
            end
            OPC_BRANCH: begin
                format_d   = FMT_B;
                sub_d      = 1'b1;
                unsigned_d = funct3[1];
            end
            OPC_LUI: begin
                format_d  = FMT_U;
                alu_imm_d = 1'b1;
                wb_sel_d  = 2'b11;
                writes_d  = 1'b1;
            end
            OPC_AUIPC: begin
                format_d  = FMT_U;
                alu_imm_d = 1'b1;
                alu_pc_d  = 1'b1;
                writes_d  = 1'b1;
            end
            OPC_JAL: begin
                format_d  = FMT_J;
                alu_imm_d = 1'b1;
                alu_pc_d  = 1'b1;
                wb_sel_d  = 2'b10;
                writes_d  = 1'b1;
            end
            OPC_JALR: begin
                format_d  = FMT_I;
                alu_imm_d = 1'b1;
                wb_sel_d  = 2'b10;
                writes_d  = 1'b1;
            end
            default: bad_d = 1'b1;
        endcase
    end

    // Side effects are suppressed for any undecodable instruction, even when
    // the illegal flag itself is compiled out.
    assign reg_we_d  = writes_d & ~bad_d & (rd_d != 5'd0);
    assign dmem_we_d = stores_d & ~bad_d;
    assign dmem_re_d = loads_d & ~bad_d;
    assign illegal_d = EN_ILLEGAL ? bad_d : 1'b0;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [5:0]      format_q;
    logic            alu_imm_q, alu_pc_q;
    logic [1:0]      wb_sel_q;
    logic            reg_we_q, dmem_we_q, dmem_re_q;
    logic [2:0]      opsel_q;
    logic            sub_q, arith_q, unsigned_q, muldiv_q, illegal_q;

    logic uses_rs1, uses_rs2, stall, ready, accept;

    assign uses_rs1 = |format_d[3:0];
    assign uses_rs2 = format_d[0] | format_d[2] | format_d[3];

    // Load in the slot whose rd is read by the offered instruction.
    assign stall = valid_q & dmem_re_q & (rd_q != 5'd0) & i_valid &
                   ((uses_rs1 & (rs1_d == rd_q)) | (uses_rs2 & (rs2_d == rd_q)));

    assign ready  = (~valid_q | i_ready) & ~stall & ~i_flush & ~i_rst;
    assign accept = i_valid & ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            format_q   <= '0;
            alu_imm_q  <= 1'b0;
            alu_pc_q   <= 1'b0;
            wb_sel_q   <= '0;
            reg_we_q   <= 1'b0;
            dmem_we_q  <= 1'b0;
            dmem_re_q  <= 1'b0;
            opsel_q    <= '0;
            sub_q      <= 1'b0;
            arith_q    <= 1'b0;
            unsigned_q <= 1'b0;
            muldiv_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            pc_q       <= i_pc;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            format_q   <= format_d;
            alu_imm_q  <= alu_imm_d;
            alu_pc_q   <= alu_pc_d;
            wb_sel_q   <= wb_sel_d;
            reg_we_q   <= reg_we_d;
            dmem_we_q  <= dmem_we_d;
            dmem_re_q  <= dmem_re_d;
            opsel_q    <= opsel_d;
            sub_q      <= sub_d;
            arith_q    <= arith_d;
            unsigned_q <= unsigned_d;
            muldiv_q   <= muldiv_d;
            illegal_q  <= illegal_d;
        end else if (i_flush | i_ready) begin
            // Slot empties (flush or drain with nothing new); kill side effects.
            valid_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            dmem_we_q <= 1'b0;
            dmem_re_q <= 1'b0;
        end
    end

    assign o_ready    = ready;
    assign o_stall    = stall;
    assign o_valid    = valid_q;
    assign o_pc       = pc_q;
    assign o_rs1      = rs1_q;
    assign o_rs2      = rs2_q;
    assign o_rd       = rd_q;
    assign o_format   = format_q;
    assign o_alu_imm  = alu_imm_q;
    assign o_alu_pc   = alu_pc_q;
    assign o_wb_sel   = wb_sel_q;
    assign o_reg_we   = reg_we_q;
    assign o_dmem_we  = dmem_we_q;
    assign o_dmem_re  = dmem_re_q;
    assign o_opsel    = opsel_q;
    assign o_sub      = sub_q;
    assign o_arith    = arith_q;
    assign o_unsigned = unsigned_q;
    assign o_muldiv   = muldiv_q;
    assign o_illegal  = illegal_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32; width of the PC path.
REQ-002 Parameter EN_MULDIV, default 0; when 1, RV32M ops (OP, funct7=0000001) are decoded; when 0 they are illegal.
REQ-003 Parameter EN_ILLEGAL, default 1; when 0, o_illegal SHALL be tied to 0.
REQ-004 Clock and reset: i_clk in 1 (single clock, rising edge); i_rst in 1 (synchronous, active-high).
REQ-005 Fetch-side ports: i_valid in 1 (instruction offered); o_ready out 1 (stage accepts); i_inst in 32; i_pc in XLEN.
REQ-006 Control-side ports: i_ready in 1 (execute accepts); i_flush in 1 (discard in-flight work).
REQ-007 Output handshake and fields: o_valid out 1; o_pc out XLEN; o_rs1, o_rs2, o_rd out 5 each; o_stall out 1 (load-use hazard active).
REQ-008 Format and datapath selects: o_format out 6, one-hot [0]R [1]I [2]S [3]B [4]U [5]J; o_alu_imm out 1 (ALU B = immediate); o_alu_pc out 1 (ALU A = PC); o_wb_sel out 2 (00 ALU, 01 load data, 10 PC+4, 11 immediate).
REQ-009 Write enables and ALU controls: o_reg_we, o_dmem_we, o_dmem_re out 1 each; o_opsel out 3; o_sub, o_arith, o_unsigned, o_muldiv, o_illegal out 1 each.

Function
REQ-010 Single register stage, latency 1: an instruction accepted at edge N SHALL appear on the outputs after edge N, with o_valid=1.
REQ-011 Acceptance SHALL occur only when i_valid & o_ready; o_ready = (~o_valid | i_ready) & ~o_stall & ~i_flush.
REQ-012 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-013 When o_valid=1, i_ready=1 and nothing is accepted, o_valid SHALL clear on the next edge (bubble).
REQ-014 o_stall SHALL be 1 when all hold: o_valid=1; o_dmem_re=1; o_rd!=0; i_valid=1; the incoming instruction reads o_rd through rs1 (R/I/S/B) or rs2 (R/S/B).
REQ-015 During a stall, the held load SHALL drain normally; the dependent instruction SHALL be accepted on the first cycle o_stall deasserts. This yields exactly one bubble when i_ready=1.
REQ-016 i_flush SHALL take priority over acceptance and hold: on the next edge o_valid=0 and no instruction is accepted.
REQ-017 o_reg_we, o_dmem_we and o_dmem_re SHALL be 0 whenever o_valid=0 or o_illegal=1.
REQ-018 o_reg_we SHALL be 0 when rd=0; it SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR.
REQ-019 OP and OP-IMM: o_opsel=funct3; o_unsigned=funct3[0].
REQ-020 o_sub SHALL be 1 for OP with funct3=000 and funct7[5]=1, and for BRANCH.
REQ-021 o_arith SHALL be 1 for SRA and SRAI only (funct3=101, funct7[5]=1).
REQ-022 BRANCH: o_opsel=000; o_unsigned=funct3[1].
REQ-023 LOAD, STORE, AUIPC, JAL and JALR: o_opsel=000 and o_sub=0.
REQ-024 o_alu_imm SHALL be 1 for I, S, U and J formats; o_alu_pc SHALL be 1 for AUIPC and JAL.
REQ-025 o_muldiv SHALL be 1 only for OP with funct7=0000001 and EN_MULDIV=1.
REQ-026 o_illegal SHALL be 1 when inst[1:0]!=11, when the opcode is outside {OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR}, or when OP funct7 is not in {0000000, 0100000, and 0000001 if EN_MULDIV}.
REQ-027 An illegal instruction SHALL still propagate with o_valid=1, so that the trap is taken downstream.

Reset
REQ-028 On i_rst=1 at a clock edge, all outputs SHALL be 0 on the next cycle; o_ready SHALL be 1 the cycle after reset deasserts.
REQ-029 Reset SHALL override flush, stall and handshake; any instruction in flight SHALL be discarded.

Verification
REQ-030 Basic R-type: i_inst=0x002081B3 (add x3,x1,x2), i_ready=1 -> next cycle o_valid=1, o_format=000001, o_rd=3, o_reg_we=1, o_opsel=000, o_sub=0, o_wb_sel=00.
REQ-031 Subtract: i_inst=0x402081B3 -> o_sub=1, o_arith=0, o_opsel=000.
REQ-032 Load-use: 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1), i_ready=1 -> o_stall=1 and o_ready=0 for exactly one cycle; add emerges two cycles after the lw.
REQ-033 Backpressure: i_ready=0 for 3 cycles with o_valid=1 -> outputs unchanged, o_ready=0; the first i_ready=1 edge drains the instruction.
REQ-034 Flush: i_flush=1 with o_valid=1 and i_valid=1 -> next cycle o_valid=0; the offered instruction is not consumed.
REQ-035 Illegal and mid-operation reset: i_inst=0xFFFFFFFF -> o_illegal=1, o_reg_we=0; assert i_rst mid-stall -> all outputs 0 on the next cycle.
